execute_stage: RTL

- Y86-64 pipeline execute stage.
- Holds the E pipeline register, which captures the decode-stage outputs (d_*), plus the ALU, the condition-code register and branch/cmov condition evaluation.
- Drives e_dstE/e_valE back to decode forwarding, and drives the inputs of the M pipeline register.

---
 rtl/execute_stage_if.sv | 31 +++
 rtl/execute_stage.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/execute_stage_if.sv
// Execute-stage bus: decode-stage inputs into the E register and results toward
// the M register, decode forwarding and hazard detection.
interface execute_stage_if;
   logic        E_bubble;
   logic [1:0]  d_stat;
   logic [3:0]  d_icode, d_ifun;
   logic [63:0] d_valC, d_valA, d_valB;
   logic [3:0]  d_dstE, d_dstM, d_srcA, d_srcB;
   logic [1:0]  m_stat, W_stat;
   logic [3:0]  E_icode, E_dstM, E_srcA, E_srcB;
   logic [1:0]  e_stat;
   logic [3:0]  e_icode;
   logic        e_Cnd;
   logic [63:0] e_valE, e_valA;
   logic [3:0]  e_dstE, e_dstM;
   logic [2:0]  cc;

   modport master (
      output E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
             d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat,
      input  E_icode, E_dstM, E_srcA, E_srcB, e_stat, e_icode, e_Cnd,
             e_valE, e_valA, e_dstE, e_dstM, cc
   );

   modport slave (
      input  E_bubble, d_stat, d_icode, d_ifun, d_valC, d_valA, d_valB,
             d_dstE, d_dstM, d_srcA, d_srcB, m_stat, W_stat,
      output E_icode, E_dstM, E_srcA, E_srcB, e_stat, e_icode, e_Cnd,
             e_valE, e_valA, e_dstE, e_dstM, cc
   );
endinterface

// File: rtl/execute_stage.sv
// Y86-64 execute stage: E pipeline register, ALU, condition codes and branch/cmov
// condition. Optional macro EXEC_IFUN_CHECK_EN flags invalid ifun as INS.
module execute_stage #(
   parameter logic [3:0] RNONE    = 4'd15,
   parameter logic [1:0] STAT_AOK = 2'd0
) (
   input logic           clk,
   input logic           rst_n,
   execute_stage_if.slave bus
);

   localparam logic [1:0] STAT_INS = 2'd3;

   logic [1:0]  E_stat;
   logic [3:0]  E_icode, E_ifun;
   logic [63:0] E_valC, E_valA, E_valB;
   logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;
   logic [2:0]  cc_q;

   logic [63:0] alu_a, alu_b, alu_r;
   logic [1:0]  alu_fun;
   logic        alu_of;
   logic [2:0]  new_cc;
   logic        set_cc, invalid, cond, is_cond;
   logic        zf, sf, of;

   always_ff @(posedge clk) begin
      if (!rst_n || bus.E_bubble) begin
         E_stat  <= STAT_AOK;
         E_icode <= 4'd1;
         E_ifun  <= 4'd0;
         E_valC  <= 64'd0;
         E_valA  <= 64'd0;
         E_valB  <= 64'd0;
         E_dstE  <= RNONE;
         E_dstM  <= RNONE;
         E_srcA  <= RNONE;
         E_srcB  <= RNONE;
      end else begin
         E_stat  <= bus.d_stat;
         E_icode <= bus.d_icode;
         E_ifun  <= bus.d_ifun;
         E_valC  <= bus.d_valC;
         E_valA  <= bus.d_valA;
         E_valB  <= bus.d_valB;
         E_dstE  <= bus.d_dstE;
         E_dstM  <= bus.d_dstM;
         E_srcA  <= bus.d_srcA;
         E_srcB  <= bus.d_srcB;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cc_q <= 3'b100;
      end else if (set_cc) begin
         cc_q <= new_cc;
      end
   end

   always_comb begin
      alu_a = 64'd0;
      alu_b = 64'd0;
      case (E_icode)
         4'd2, 4'd6:        alu_a = E_valA;
         4'd3, 4'd4, 4'd5:  alu_a = E_valC;
         4'd8, 4'd10:       alu_a = 64'hFFFF_FFFF_FFFF_FFF8;
         4'd9, 4'd11:       alu_a = 64'd8;
         default:           alu_a = 64'd0;
      endcase
      case (E_icode)
         4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11: alu_b = E_valB;
         default:                                   alu_b = 64'd0;
      endcase
   end

   // Out-of-range OPq functions fall back to add.
   assign alu_fun = (E_icode == 4'd6 && E_ifun <= 4'd3) ? E_ifun[1:0] : 2'd0;

   always_comb begin
      alu_r  = 64'd0;
      alu_of = 1'b0;
      unique case (alu_fun)
         2'd0: begin
            alu_r  = alu_b + alu_a;
            alu_of = (alu_a[63] == alu_b[63]) && (alu_r[63] != alu_a[63]);
         end
         2'd1: begin
            alu_r  = alu_b - alu_a;
            alu_of = (alu_a[63] != alu_b[63]) && (alu_r[63] != alu_b[63]);
         end
         2'd2: alu_r = alu_b & alu_a;
         2'd3: alu_r = alu_b ^ alu_a;
      endcase
   end

   assign new_cc = {alu_r == 64'd0, alu_r[63], alu_of};

`ifdef EXEC_IFUN_CHECK_EN
   assign invalid = (E_stat == STAT_AOK) &&
                    ((E_icode == 4'd6 && E_ifun > 4'd3) ||
                     ((E_icode == 4'd2 || E_icode == 4'd7) && E_ifun > 4'd6));
`else
   assign invalid = 1'b0;
`endif

   assign set_cc = (E_icode == 4'd6) && (E_stat == STAT_AOK) && (bus.m_stat == STAT_AOK) &&
                   (bus.W_stat == STAT_AOK) && !invalid;

   assign zf = cc_q[2];
   assign sf = cc_q[1];
   assign of = cc_q[0];

   // Conditions read the registered flags, never this instruction's own result.
   always_comb begin
      cond = 1'b0;
      case (E_ifun)
         4'd0:    cond = 1'b1;
         4'd1:    cond = (sf ^ of) | zf;
         4'd2:    cond = sf ^ of;
         4'd3:    cond = zf;
         4'd4:    cond = !zf;
         4'd5:    cond = !(sf ^ of);
         4'd6:    cond = !(sf ^ of) && !zf;
         default: cond = 1'b0;
      endcase
   end

   assign is_cond = (E_icode == 4'd2) || (E_icode == 4'd7);

   assign bus.e_Cnd   = is_cond && cond;
   assign bus.e_valE  = alu_r;
   assign bus.e_valA  = E_valA;
   assign bus.e_icode = E_icode;
   assign bus.e_stat  = invalid ? STAT_INS : E_stat;
   assign bus.e_dstE  = (invalid || (E_icode == 4'd2 && !bus.e_Cnd)) ? RNONE : E_dstE;
   assign bus.e_dstM  = invalid ? RNONE : E_dstM;
   assign bus.E_icode = E_icode;
   assign bus.E_dstM  = E_dstM;
   assign bus.E_srcA  = E_srcA;
   assign bus.E_srcB  = E_srcB;
   assign bus.cc      = cc_q;

endmodule
